rr_arb_mux_4: RTL and testbench
===============================

RR_ARB_MUX_4 -- requirements
Module: rr_arb_mux_4

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each requester channel and the output.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req  input  4  per-requester request; bit i belongs to requester i.
REQ-006 Port: din0, din1, din2, din3  input  WIDTH each  requester data, held stable while req[i]=1.
REQ-007 Port: ack  output  4  one-hot, one-cycle pulse; ack[i]=1 marks the cycle requester i's data is taken.
REQ-008 Port: out_data  output  WIDTH  shared-path data, equal to din[sel].
REQ-009 Port: out_valid  output  1  out_data is valid this cycle.
REQ-010 Port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 Port: sel  output  2  index of the currently granted requester.
REQ-012 Port: xfer_count  output  16  number of completed transfers, wrapping.

Function
REQ-013 The FSM SHALL have two states: IDLE and GRANT.
REQ-014 out_data SHALL be a combinational 4:1 selection of din0..din3 by sel, with 0 cycles of latency from din or sel.
REQ-015 out_valid SHALL equal (state==GRANT) AND req[sel].
REQ-016 Transfer SHALL be defined as out_valid=1 AND out_ready=1 in the same cycle.
REQ-017 ack[sel] SHALL be driven combinationally high only in a transfer cycle; all other ack bits SHALL be 0.
REQ-018 A round-robin pointer ptr (2 bits) SHALL set priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-019 IDLE with req!=0: next state GRANT; sel <= first set bit of req in ptr order; grant latency 1 cycle.
REQ-020 IDLE with req==0: remain IDLE; sel and ptr unchanged.
REQ-021 GRANT with transfer: ptr <= sel+1 mod 4; xfer_count <= xfer_count+1 (wrap 0xFFFF->0x0000).
REQ-022 GRANT with transfer and (req with bit sel cleared)!=0: remain GRANT; sel <= first set bit of that masked vector in order sel+1.. (mod 4); no bubble.
REQ-023 GRANT with transfer and masked vector==0: next state IDLE.
REQ-024 GRANT with req[sel]=0 (withdrawal): next state IDLE; no ack; ptr and xfer_count unchanged.
REQ-025 GRANT with out_valid=1 and out_ready=0: hold state and sel; sel SHALL NOT change while a grant is pending.
REQ-026 Requests arriving while in GRANT SHALL NOT preempt the current grant.

Reset
REQ-027 On reset assertion, asynchronously: state=IDLE, sel=0, ptr=0, xfer_count=0.
REQ-028 During and directly after reset: out_valid=0, ack=0000, out_data=din0.
REQ-029 Reset asserted mid-grant SHALL abort the grant with no ack and no count increment.

Structure
REQ-030 Shared package arb_pkg SHALL hold: the state enum (IDLE, GRANT), NUM_REQ=4, SEL_W=2, CNT_W=16.
REQ-031 The round-robin winner search SHALL be one sub-module, rr_pick4: inputs are the 4-bit request vector and a 2-bit start index; outputs are the 2-bit winner index and an any-flag.
REQ-032 The 4:1 data selection SHALL be inline in rr_arb_mux_4.

Verification
REQ-033 Reset, then req=0100, din2=0xA5, out_ready=1 -> GRANT one cycle later, sel=2, out_data=0xA5, ack=0100 for one cycle, xfer_count=1, ptr=3.
REQ-034 req=1111 held, out_ready=1, from reset -> grant order 0,1,2,3,0 with no idle cycles; ack sequence 0001,0010,0100,1000,0001.
REQ-035 sel=1 granted, out_ready=0 for 5 cycles while req=1111 -> sel stays 1, ack=0000, out_valid=1 throughout; out_ready=1 -> ack=0010, next sel=2.
REQ-036 sel=3 granted, req[3] dropped before out_ready -> IDLE next cycle, no ack, xfer_count unchanged, ptr unchanged.
REQ-037 Preload xfer_count to 0xFFFF through 65535 transfers, then one more transfer -> xfer_count=0x0000.
REQ-038 Reset asserted mid-GRANT with out_ready=0 -> out_valid=0 and sel=0 immediately (asynchronous), ack never pulses.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 4-requester round-robin arbiter/mux.
// Holds the two-state FSM encoding and the requester/index/counter widths
// used by rr_pick4 and rr_arb_mux_4.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin winner search over four request bits.
// Ports: req_vec (4 request bits), start (highest-priority index),
//        win (first set bit at or after start, wrapping), any (req_vec != 0).
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [SEL_W-1:0]   start,
  output logic [SEL_W-1:0]   win,
  output logic               any
);

  logic [SEL_W-1:0] idx;

  // Walk priorities from lowest to highest so the last hit is the nearest
  // set bit to start. idx is SEL_W wide, so start+k wraps mod 4 for free.
  always_comb begin
    win = start;
    idx = start;
    any = |req_vec;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + SEL_W'(k);
      if (req_vec[idx]) begin
        win = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux_4.sv
// Four-way round-robin arbiter with shared 4:1 data path and transfer counter.
// Ports: clk/reset (async active-high); req/din0..din3 from requesters;
//        ack one-hot pulse on transfer; out_data/out_valid/out_ready
//        downstream handshake; sel current grant index; xfer_count transfers.
module rr_arb_mux_4
  import arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [WIDTH-1:0]     din0,
  input  logic [WIDTH-1:0]     din1,
  input  logic [WIDTH-1:0]     din2,
  input  logic [WIDTH-1:0]     din3,
  output logic [NUM_REQ-1:0]   ack,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     sel,
  output logic [CNT_W-1:0]     xfer_count
);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [NUM_REQ-1:0] req_rest;
  logic [NUM_REQ-1:0] pick_req;
  logic [SEL_W-1:0]   pick_start;
  logic [SEL_W-1:0]   pick_win;
  logic               pick_any;
  logic               xfer;

  // Shared data path: pure combinational select, so sel changes show up
  // on out_data in the same cycle.
  always_comb begin
    case (sel)
      2'd0:    out_data = din0;
      2'd1:    out_data = din1;
      2'd2:    out_data = din2;
      default: out_data = din3;
    endcase
  end

  assign out_valid = (state == GRANT) && req[sel];
  assign xfer      = out_valid && out_ready;
  assign ack       = xfer ? (NUM_REQ'(1) << sel) : '0;

  // Requests other than the one being served, used to chain straight into
  // the next grant without an idle cycle.
  assign req_rest = req & ~(NUM_REQ'(1) << sel);

  // One search serves both states: from IDLE it scans all requests from
  // ptr; in GRANT it scans the remaining requests starting just after sel.
  assign pick_req   = (state == IDLE) ? req : req_rest;
  assign pick_start = (state == IDLE) ? ptr : sel + SEL_W'(1);

  rr_pick4 u_pick (
    .req_vec (pick_req),
    .start   (pick_start),
    .win     (pick_win),
    .any     (pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= '0;
      ptr        <= '0;
      xfer_count <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      ptr        <= ptr_nxt;
      xfer_count <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    cnt_nxt   = xfer_count;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          sel_nxt   = pick_win;
        end
      end
      GRANT: begin
        if (xfer) begin
          ptr_nxt = sel + SEL_W'(1);
          cnt_nxt = xfer_count + CNT_W'(1);
          if (pick_any) begin
            sel_nxt = pick_win;
          end else begin
            state_nxt = IDLE;
          end
        end else if (!req[sel]) begin
          // Requester withdrew before being served: drop the grant quietly.
          state_nxt = IDLE;
        end
        // Otherwise the grant is stalled by out_ready=0 and everything holds.
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arb_mux_4.sv
module tb_rr_arb_mux_4;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       req = 4'b0000;
  logic [WIDTH-1:0] din0 = 8'h11;
  logic [WIDTH-1:0] din1 = 8'h22;
  logic [WIDTH-1:0] din2 = 8'h33;
  logic [WIDTH-1:0] din3 = 8'h44;
  logic             out_ready = 1'b0;
  logic [3:0]       ack;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [1:0]       sel;
  logic [15:0]      xfer_count;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arb_mux_4 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .ack        (ack),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel        (sel),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks "who holds the grant", the next-priority pointer and the count.
  bit          m_busy = 0;
  logic [1:0]  m_sel  = 2'd0;
  logic [1:0]  m_ptr  = 2'd0;
  logic [15:0] m_cnt  = 16'd0;

  function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] s);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (int'(s) + k) % 4;
      if (v[i]) return 2'(i);
    end
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] din_of(input logic [1:0] i);
    case (i)
      2'd0: return din0;
      2'd1: return din1;
      2'd2: return din2;
      default: return din3;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0;
      m_sel  = 2'd0;
      m_ptr  = 2'd0;
      m_cnt  = 16'd0;
    end else if (!m_busy) begin
      if (req != 4'b0000) begin
        m_busy = 1;
        m_sel  = pick(req, m_ptr);
      end
    end else if (req[m_sel] && out_ready) begin
      logic [3:0] others;
      others = req;
      others[m_sel] = 1'b0;
      m_cnt = m_cnt + 16'd1;
      m_ptr = m_sel + 2'd1;
      if (others != 4'b0000) m_sel = pick(others, m_sel + 2'd1);
      else m_busy = 0;
    end else if (!req[m_sel]) begin
      m_busy = 0;
    end
  end

  // Compare process: every negedge, DUT outputs against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_count", 32'(xfer_count), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'(din0));
    end else begin
      logic       ev;
      logic [3:0] ea;
      ev = m_busy && req[m_sel];
      ea = (ev && out_ready) ? (4'b0001 << m_sel) : 4'b0000;
      chk("mdl_out_valid", 32'(out_valid), 32'(ev));
      chk("mdl_ack", 32'(ack), 32'(ea));
      chk("mdl_sel", 32'(sel), 32'(m_sel));
      chk("mdl_out_data", 32'(out_data), 32'(din_of(m_sel)));
      chk("mdl_count", 32'(xfer_count), 32'(m_cnt));
    end
  end

  // ---------------- directed stimulus ----------------
  // Inputs change 2 time units after the rising edge; literal checks at +3.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_data_din0", 32'(out_data), 32'h11);
    do_reset();

    // Single requester 2, immediate acceptance
    din2 = 8'hA5;
    req = 4'b0100;
    out_ready = 1'b1;
    #1;
    chk("t1_idle_valid", 32'(out_valid), 32'd0);
    tick(); #1;
    chk("t1_sel", 32'(sel), 32'd2);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'hA5);
    chk("t1_ack", 32'(ack), 32'b0100);
    tick(); #1;
    chk("t1_ack_gone", 32'(ack), 32'd0);
    chk("t1_count", 32'(xfer_count), 32'd1);
    req = 4'b1111;
    tick(); #1;
    chk("t1_ptr_is_3", 32'(sel), 32'd3);

    // All requesting, no bubbles: 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_sel", 32'(sel), 32'(k % 4));
      chk("t2_ack", 32'(ack), 32'(4'b0001 << (k % 4)));
      tick();
    end

    // Stall on sel=1 for five cycles
    do_reset();
    req = 4'b1111;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_sel_hold", 32'(sel), 32'd1);
      chk("t3_no_ack", 32'(ack), 32'd0);
      chk("t3_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t3_ack", 32'(ack), 32'b0010);
    tick(); #1;
    chk("t3_next_sel", 32'(sel), 32'd2);

    // Withdrawal of requester 3
    do_reset();
    req = 4'b1000;
    tick(); #1;
    chk("t4_sel", 32'(sel), 32'd3);
    chk("t4_valid", 32'(out_valid), 32'd1);
    req = 4'b0000;
    out_ready = 1'b1;
    #1;
    chk("t4_valid_drop", 32'(out_valid), 32'd0);
    chk("t4_no_ack", 32'(ack), 32'd0);
    tick(); #1;
    chk("t4_count", 32'(xfer_count), 32'd0);
    req = 4'b1111;
    tick(); #1;
    chk("t4_ptr_kept", 32'(sel), 32'd0);

    // Counter wrap: two requesters alternate, one transfer per cycle
    do_reset();
    req = 4'b0011;
    out_ready = 1'b1;
    tick();
    repeat (65535) tick();
    #1;
    chk("t5_count_ffff", 32'(xfer_count), 32'hFFFF);
    tick(); #1;
    chk("t5_count_wrap", 32'(xfer_count), 32'h0000);

    // Reset in the middle of a stalled grant
    do_reset();
    req = 4'b0100;
    tick(); #1;
    chk("t6_sel", 32'(sel), 32'd2);
    chk("t6_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_sel", 32'(sel), 32'd0);
    chk("t6_async_ack", 32'(ack), 32'd0);
    chk("t6_async_data", 32'(out_data), 32'h11);
    tick();
    reset = 1'b0;
    req = 4'b0000;
    tick(); #1;
    chk("t6_count", 32'(xfer_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
